// File: rtl/prbs7_burst_ctrl_if.sv
// Command and bit-stream handshakes for the PRBS7 burst controller.
// The slave side is the controller; the master side is the command source and bit sink.
interface prbs7_burst_ctrl_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load_seed;
  logic [6:0]       cmd_seed;
  logic [LEN_W-1:0] cmd_len;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_ready;

  modport master (
    output cmd_valid,
    input  cmd_ready,
    output cmd_load_seed,
    output cmd_seed,
    output cmd_len,
    input  bit_out,
    input  bit_valid,
    output bit_ready
  );

  modport slave (
    input  cmd_valid,
    output cmd_ready,
    input  cmd_load_seed,
    input  cmd_seed,
    input  cmd_len,
    output bit_out,
    output bit_valid,
    input  bit_ready
  );
endinterface

// File: rtl/prbs7_burst_ctrl.sv
// Command-driven PRBS7 burst sequencer with valid/ready bit stream.
// Streams cmd_len bits of x^7+x^6+1 then pulses done; rejects lock-up commands.
module prbs7_burst_ctrl #(
  parameter int         LEN_W        = 8,
  parameter logic [6:0] DEFAULT_SEED = 7'h7F
) (
  input  logic              clk,
  input  logic              rst,
  prbs7_burst_ctrl_if.slave bus,
  input  logic              abort,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [6:0]        state_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           st;
  state_t           st_nx;
  logic [6:0]       lfsr;
  logic [6:0]       lfsr_nx;
  logic [LEN_W-1:0] cnt;
  logic             cmd_ready;
  logic             bit_valid;
  logic             accept;
  logic             bad;
  logic             xfer;

  assign accept  = bus.cmd_valid & cmd_ready;
  assign bad     = (bus.cmd_len == '0)
                 | (bus.cmd_load_seed & (bus.cmd_seed == 7'h00));
  // abort wins over a transfer in the same cycle
  assign xfer    = bit_valid & bus.bit_ready & ~abort;
  assign lfsr_nx = {lfsr[5:0], lfsr[0] ^ lfsr[6]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
    end else begin
      st <= st_nx;
    end
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE: begin
        if (accept & ~bad) st_nx = RUN;
      end
      RUN: begin
        if (abort) st_nx = IDLE;
        else if (xfer & (cnt == LEN_W'(1))) st_nx = DONE;
      end
      DONE:    st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    bit_valid = 1'b0;
    done      = 1'b0;
    busy      = 1'b0;
    unique case (st)
      IDLE: cmd_ready = 1'b1;
      RUN: begin
        bit_valid = 1'b1;
        busy      = 1'b1;
      end
      DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= DEFAULT_SEED;
      cnt  <= '0;
      err  <= 1'b0;
    end else begin
      err <= accept & bad;
      if (accept & ~bad) begin
        if (bus.cmd_load_seed) lfsr <= bus.cmd_seed;
        cnt <= bus.cmd_len;
      end else if (xfer) begin
        lfsr <= lfsr_nx;
        cnt  <= cnt - LEN_W'(1);
      end
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.bit_valid = bit_valid;
  assign bus.bit_out   = lfsr[6];
  assign state_out     = lfsr;

endmodule
